rps_match_scoreboard: RTL

Downstream of the stone-paper-scissors round evaluator, this block turns single-round results into a best-of-N match. It watches the evaluator's state and winner outputs and counts one round on each entry into the result state. It keeps per-player win counts, draws, rounds played and a sticky invalid-move flag, and declares the match winner when a player reaches the win target or the round limit is exhausted.

---
 rtl/rps_match_scoreboard.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rps_match_scoreboard.sv
// ============================================================================
// rps_match_scoreboard
// Best-of-N match scoring on top of the single-round evaluator outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rps_match_scoreboard #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_state,
  input  logic [1:0] in_winner,
  input  logic       clear,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] draws,
  output logic [3:0] rounds,
  output logic       round_strobe,
  output logic       bad_round,
  output logic       match_done,
  output logic [1:0] match_winner
);

  localparam logic [2:0] ST_RESULT = 3'b010;
  localparam logic [3:0] WIN_TGT   = 4'(WIN_TARGET);
  localparam logic [3:0] RND_LIMIT = 4'(MAX_ROUNDS);

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] prev_state_q;
  logic [3:0] p1_q, p1_d;
  logic [3:0] p2_q, p2_d;
  logic [3:0] draws_q, draws_d;
  logic [3:0] rounds_q, rounds_d;
  logic       strobe_q, strobe_d;
  logic       bad_q, bad_d;
  logic       done_q, done_d;
  logic [1:0] winner_q, winner_d;
  logic       round_evt;

  // One event per entry into the result state, regardless of hold length.
  assign round_evt = (in_state == ST_RESULT) && (prev_state_q != ST_RESULT);

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    draws_d  = draws_q;
    rounds_d = rounds_q;
    strobe_d = 1'b0;
    bad_d    = bad_q;
    done_d   = done_q;
    winner_d = winner_q;

    if (clear) begin
      state_d  = PLAY;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      draws_d  = 4'd0;
      rounds_d = 4'd0;
      bad_d    = 1'b0;
      done_d   = 1'b0;
      winner_d = 2'b00;
    end else if ((state_q == PLAY) && round_evt) begin
      strobe_d = 1'b1;
      case (in_winner)
        2'b01: begin
          p1_d     = p1_q + 4'd1;
          rounds_d = rounds_q + 4'd1;
        end
        2'b10: begin
          p2_d     = p2_q + 4'd1;
          rounds_d = rounds_q + 4'd1;
        end
        2'b00: begin
          if (draws_q != 4'hF) draws_d = draws_q + 4'd1;
          rounds_d = rounds_q + 4'd1;
        end
        default: bad_d = 1'b1;
      endcase

      // End-of-match test works on the freshly updated counts.
      if (p1_d == WIN_TGT) begin
        state_d  = OVER;
        done_d   = 1'b1;
        winner_d = 2'b01;
      end else if (p2_d == WIN_TGT) begin
        state_d  = OVER;
        done_d   = 1'b1;
        winner_d = 2'b10;
      end else if (rounds_d == RND_LIMIT) begin
        state_d  = OVER;
        done_d   = 1'b1;
        winner_d = (p1_d > p2_d) ? 2'b01 : ((p2_d > p1_d) ? 2'b10 : 2'b00);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLAY;
      prev_state_q <= 3'b000;
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
      draws_q      <= 4'd0;
      rounds_q     <= 4'd0;
      strobe_q     <= 1'b0;
      bad_q        <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      prev_state_q <= in_state;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      draws_q      <= draws_d;
      rounds_q     <= rounds_d;
      strobe_q     <= strobe_d;
      bad_q        <= bad_d;
      done_q       <= done_d;
      winner_q     <= winner_d;
    end
  end

  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign draws        = draws_q;
  assign rounds       = rounds_q;
  assign round_strobe = strobe_q;
  assign bad_round    = bad_q;
  assign match_done   = done_q;
  assign match_winner = winner_q;

endmodule

`default_nettype wire
